mult_io_ctrl: RTL and testbench

Handshake front/back end for the sequential Booth multiplier. The block accepts a signed operand pair on a valid/ready input port and holds it stable on the multiplier's operand inputs. It sequences the multiplier's reset/run window, waits for the multiplier's `Fin`, and captures the 2·SIZE-bit signed product. The product is then presented on a valid/ready output port. It sits directly upstream and downstream of the multiplier control unit plus its datapath, which it drives through `mul_reset` and observes through `mul_fin`/`mul_product`.

---
 rtl/mult_io_ctrl.sv | 128 ++++++++++++
 tb/tb_mult_io_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_io_ctrl.sv
// Valid/ready front and back end for the sequential Booth multiplier.
// Optional RUN watchdog is enabled by defining MULT_IO_TIMEOUT_EN.
module mult_io_ctrl #(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    output logic              in_ready,
    output logic              mul_reset,
    output logic [SIZE-1:0]   mul_m,
    output logic [SIZE-1:0]   mul_q,
    input  logic              mul_fin,
    input  logic [2*SIZE-1:0] mul_product,
    output logic              out_valid,
    output logic [2*SIZE-1:0] out_product,
    output logic              out_err,
    input  logic              out_ready,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and offered data holds until the transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SIZE-1:0]     m_q, m_d;
    logic [SIZE-1:0]     q_q, q_d;
    logic [2*SIZE-1:0]   prod_q, prod_d;
    logic                err_q, err_d;
    logic                timeout;

`ifdef MULT_IO_TIMEOUT_EN
    localparam int WD_W = $clog2(SIZE + 4) + 1;
    // Fires in the last RUN cycle so the timed-out result lands SIZE+4 cycles after RUN entry.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(SIZE + 3);

    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_d    = (state_q == RUN) ? wd_q + 1'b1 : '0;
    assign timeout = (state_q == RUN) && (wd_q == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        prod_d    = prod_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        mul_reset = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_d     = in_a;
                    q_d     = in_b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                mul_reset = 1'b0;
                // A real Fin takes priority over a watchdog expiry in the same cycle.
                if (mul_fin) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else if (timeout) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mul_m       = m_q;
    assign mul_q       = q_q;
    assign out_valid   = (state_q == HOLD);
    assign out_product = prod_q;
    assign out_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_io_ctrl.sv
// Directed bench for mult_io_ctrl with a cycle-accurate stub of the Booth multiplier.
module tb_mult_io_ctrl;

  localparam int SIZE = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [SIZE-1:0]   in_a;
  logic [SIZE-1:0]   in_b;
  logic              in_ready;
  logic              mul_reset;
  logic [SIZE-1:0]   mul_m;
  logic [SIZE-1:0]   mul_q;
  logic              mul_fin;
  logic [2*SIZE-1:0] mul_product;
  logic              out_valid;
  logic [2*SIZE-1:0] out_product;
  logic              out_err;
  logic              out_ready;
  logic [1:0]        dbg_state;

  int n_cmp;
  int n_err;

  // multiplier stub: counter cleared by mul_reset, Fin after SIZE+1 counting edges
  logic              stub_dead;
  int                stub_cnt;
  logic [2*SIZE-1:0] stub_prod;

  mult_io_ctrl #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_ready    (in_ready),
    .mul_reset   (mul_reset),
    .mul_m       (mul_m),
    .mul_q       (mul_q),
    .mul_fin     (mul_fin),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_product (out_product),
    .out_err     (out_err),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mul_reset) stub_cnt <= 0;
    else           stub_cnt <= stub_cnt + 1;
  end

  assign stub_prod   = $signed({{SIZE{mul_m[SIZE-1]}}, mul_m}) * $signed({{SIZE{mul_q[SIZE-1]}}, mul_q});
  assign mul_fin     = !stub_dead && (stub_cnt == SIZE + 1);
  assign mul_product = mul_fin ? stub_prod : 8'hAA;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_err = 0;
    stub_dead = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_reset", mul_reset, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_m", mul_m, 0);
    check("rst_mul_q", mul_q, 0);
    check("rst_out_product", out_product, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b0;
    tick();

    // basic multiply: -3 * 5 = -15
    in_a = 4'hD; in_b = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
    check("basic_in_ready", in_ready, 1);
    tick();                                   // E0
    in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0;
    check("basic_load_m", mul_m, 4'hD);
    check("basic_load_q", mul_q, 4'h5);
    check("basic_load_ready", in_ready, 0);
    check("basic_load_mreset", mul_reset, 1);
    tick();                                   // E1
    check("basic_run_mreset", mul_reset, 0);
    check("basic_run_valid", out_valid, 0);
    for (int i = 2; i <= 6; i++) begin
      tick();
      check("basic_early_valid", out_valid, 0);
    end
    tick();                                   // E7
    check("basic_valid", out_valid, 1);
    check("basic_product", out_product, 8'hF1);
    check("basic_err", out_err, 0);
    tick();                                   // E8
    check("basic_valid_fall", out_valid, 0);
    check("basic_ready_rise", in_ready, 1);

    // output backpressure: 7 * -8 = -56
    in_a = 4'h7; in_b = 4'h8; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    tick();
    check("bp_valid", out_valid, 1);
    check("bp_product", out_product, 8'hC8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_product", out_product, 8'hC8);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_mreset", mul_reset, 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_valid_fall", out_valid, 0);
    check("bp_ready_rise", in_ready, 1);

    // asynchronous reset mid-cycle while a result is held: -1 * -1 = 1
    in_a = 4'hF; in_b = 4'hF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("ar_product", out_product, 8'h01);
    check("ar_valid", out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_product", out_product, 0);
    check("ar_mul_m", mul_m, 0);
    check("ar_mul_q", mul_q, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_mul_reset", mul_reset, 1);
    check("ar_out_err", out_err, 0);
    tick();
    reset = 1'b0;
    tick();

    // back-to-back with in_valid held high: (-8,-8) then (0,-1)
    out_ready = 1'b1;
    in_a = 4'h8; in_b = 4'h8; in_valid = 1'b1;
    tick();                                   // E0
    in_a = 4'h0; in_b = 4'hF;
    tick();                                   // E1
    for (int i = 1; i <= 6; i++) begin
      check("b2b_run_m", mul_m, 4'h8);
      check("b2b_run_q", mul_q, 4'h8);
      check("b2b_run_valid", out_valid, 0);
      tick();
    end
    check("b2b_valid1", out_valid, 1);        // E7
    check("b2b_product1", out_product, 8'h40);
    tick();                                   // E8
    check("b2b_gap_valid", out_valid, 0);
    check("b2b_gap_ready", in_ready, 1);
    tick();                                   // E9 second acceptance
    in_valid = 1'b0;
    check("b2b_load2_m", mul_m, 4'h0);
    check("b2b_load2_q", mul_q, 4'hF);
    check("b2b_load2_ready", in_ready, 0);
    for (int i = 10; i <= 15; i++) begin
      tick();
      check("b2b_run2_valid", out_valid, 0);
    end
    tick();                                   // E16
    check("b2b_valid2", out_valid, 1);
    check("b2b_product2", out_product, 8'h00);
    tick();

    // abort two cycles into RUN, then (2,3)
    in_a = 4'h5; in_b = 4'h5; in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    repeat (3) tick();                        // E1..E3
    reset = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check("abort_mreset", mul_reset, 1);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    in_a = 4'h2; in_b = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    tick();
    check("post_abort_valid", out_valid, 1);
    check("post_abort_product", out_product, 8'h06);
    tick();

    // multiplier never raises Fin
    stub_dead = 1'b1;
    in_a = 4'h1; in_b = 4'h1; in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    tick();                                   // E1 RUN entry
`ifdef MULT_IO_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("to_early_valid", seen, 0);
    tick();                                   // E9 = RUN entry + SIZE+4
    check("to_valid", out_valid, 1);
    check("to_err", out_err, 1);
    check("to_product", out_product, 0);
    stub_dead = 1'b0;
    tick();
    check("to_valid_fall", out_valid, 0);
    in_a = 4'h2; in_b = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    tick();
    check("after_to_valid", out_valid, 1);
    check("after_to_err", out_err, 0);
    check("after_to_product", out_product, 8'h06);
    tick();
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("nto_no_valid", seen, 0);
    check("nto_err", out_err, 0);
    check("nto_mreset", mul_reset, 0);
    stub_dead = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("nto_recover_ready", in_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
